scan_window_sequencer: RTL and testbench

// - Generates scanning-window coordinates across a programmable N-level image pyramid for the VJ pipeline.
// - Parametrised successor of the fixed free-running window walker:
//   - configurable stride;
//   - run-time level dimensions with skipping of undersized levels;
//   - valid/ready backpressure;
//   - start/abort/done handshake and a per-frame window count.
// - Placement: sits between the integral-image calculators (drives their read index) and vj_pipeline.

---
 rtl/vj_scan_pkg.sv | 40 ++++
 rtl/scan_coord_counter.sv | 57 +++++
 rtl/scan_window_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_scan_window_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vj_scan_pkg.sv
// Shared types for the pyramid scan-window sequencer.
//   scan_state_t         sequencer FSM states
//   coord_t              default-width row/col/dimension field
//   lvl_sel_t            result of a level search (found flag + level index)
//   next_eligible_level  lowest eligible level at or above a starting index
package vj_scan_pkg;

   localparam int MAX_LEVELS      = 16;
   localparam int COORD_W_DEFAULT = 16;

   typedef logic [COORD_W_DEFAULT-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SCAN,
      DONE
   } scan_state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] level;
   } lvl_sel_t;

   // Downward walk so the lowest matching index is the one left in r.
   function automatic lvl_sel_t next_eligible_level(input logic [MAX_LEVELS-1:0] mask,
                                                    input logic [4:0]            from);
      lvl_sel_t r;
      r.found = 1'b0;
      r.level = '0;
      for (int i = MAX_LEVELS - 1; i >= 0; i--) begin
         if (mask[i] && (5'(i) >= from)) begin
            r.found = 1'b1;
            r.level = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/scan_coord_counter.sv
// 2-D row/col stepper for one pyramid level.
//   clock, reset        system clock, synchronous active-high reset
//   clear               force (row, col) to (0, 0)
//   step                advance to the next window position
//   max_row, max_col    largest legal top-left row/col for the current level
//   row, col            current top-left position
//   wrap_row            col is in the last column (next step leaves the row)
//   wrap_frame          row is in the last row; with wrap_row, the level is finished
module scan_coord_counter #(
   parameter int COORD_W = 16,
   parameter int STRIDE  = 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               step,
   input  logic [COORD_W-1:0] max_row,
   input  logic [COORD_W-1:0] max_col,
   output logic [COORD_W-1:0] row,
   output logic [COORD_W-1:0] col,
   output logic               wrap_row,
   output logic               wrap_frame
);

   // One extra bit so that position + STRIDE can never wrap past max.
   localparam logic [COORD_W:0] STEP = (COORD_W + 1)'(STRIDE);

   logic [COORD_W:0] col_nxt;
   logic [COORD_W:0] row_nxt;

   assign col_nxt    = {1'b0, col} + STEP;
   assign row_nxt    = {1'b0, row} + STEP;
   assign wrap_row   = col_nxt > {1'b0, max_col};
   assign wrap_frame = row_nxt > {1'b0, max_row};

   always_ff @(posedge clock) begin
      if (reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (step) begin
         if (!wrap_row) begin
            col <= col_nxt[COORD_W-1:0];
         end else if (!wrap_frame) begin
            col <= '0;
            row <= row_nxt[COORD_W-1:0];
         end else begin
            // Level exhausted: the next level (if any) starts at the origin.
            col <= '0;
            row <= '0;
         end
      end
   end

endmodule

// File: rtl/scan_window_sequencer.sv
// Scanning-window coordinate generator across an N-level image pyramid.
// Sits between the integral-image calculators and the VJ pipeline.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; dims are latched when start is accepted
//   SETTLE | waiting out integral-image latency before the first window
//   SCAN   | presenting windows; advances on win_valid & win_ready
//   DONE   | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   start, abort                  frame start (IDLE only) / frame cancel
//   level_width, level_height     packed per-level dims, COORD_W bits each
//   win_valid, win_ready          window handshake
//   win_level, win_row, win_col   current window level and top-left corner
//   win_last                      current window is the final one of the frame
//   busy, done                    frame in progress / end-of-frame pulse
//   win_count                     windows accepted in the current or last frame
//
// SETTLE_CYCLES must be >= 2. The start cycle itself is the first settle
// cycle, so the counter is loaded one short of SETTLE_CYCLES; that puts the
// first win_valid exactly SETTLE_CYCLES cycles after start.
module scan_window_sequencer #(
   parameter int LEVELS        = 9,
   parameter int WINDOW_SIZE   = 24,
   parameter int STRIDE        = 1,
   parameter int COORD_W       = 16,
   parameter int SETTLE_CYCLES = 10
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      abort,
   input  logic [LEVELS*COORD_W-1:0] level_width,
   input  logic [LEVELS*COORD_W-1:0] level_height,
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic [3:0]                win_level,
   output logic [COORD_W-1:0]        win_row,
   output logic [COORD_W-1:0]        win_col,
   output logic                      win_last,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               win_count
);

   import vj_scan_pkg::*;

   // A window covers WINDOW_SIZE+1 integral-image points per side.
   localparam int               SPAN        = WINDOW_SIZE + 1;
   localparam logic [COORD_W:0] SPAN_W      = (COORD_W + 1)'(SPAN);
   localparam logic [15:0]      SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

   scan_state_t state_q;
   scan_state_t state_d;

   logic [COORD_W-1:0]    width_q  [LEVELS];
   logic [COORD_W-1:0]    height_q [LEVELS];
   logic [MAX_LEVELS-1:0] elig_in;
   logic [MAX_LEVELS-1:0] elig_q;
   logic [3:0]            level_q;
   logic [15:0]           settle_cnt;

   logic [COORD_W-1:0] cur_w;
   logic [COORD_W-1:0] cur_h;
   logic [COORD_W-1:0] max_row;
   logic [COORD_W-1:0] max_col;
   logic               wrap_row;
   logic               wrap_frame;
   logic               level_end;

   lvl_sel_t first_lvl;
   lvl_sel_t next_lvl;

   logic start_ok;
   logic enter_scan;
   logic accept;
   logic frame_end;

   // Eligibility of the live input dims, used to decide SETTLE vs DONE at start.
   always_comb begin
      elig_in = '0;
      for (int l = 0; l < LEVELS; l++) begin
         elig_in[l] = ({1'b0, level_width[l*COORD_W +: COORD_W]}  >= SPAN_W) &&
                      ({1'b0, level_height[l*COORD_W +: COORD_W]} >= SPAN_W);
      end
   end

   always_comb begin
      cur_w = '0;
      cur_h = '0;
      for (int l = 0; l < LEVELS; l++) begin
         if (level_q == 4'(l)) begin
            cur_w = width_q[l];
            cur_h = height_q[l];
         end
      end
   end

   // Only consulted in SCAN, where the current level is eligible, so no underflow.
   assign max_col = cur_w - COORD_W'(SPAN);
   assign max_row = cur_h - COORD_W'(SPAN);

   assign first_lvl = next_eligible_level(elig_q, 5'd0);
   assign next_lvl  = next_eligible_level(elig_q, {1'b0, level_q} + 5'd1);

   assign start_ok   = (state_q == IDLE) && start && !abort;
   assign enter_scan = (state_q == SETTLE) && !abort && (settle_cnt <= 16'd1);
   assign accept     = (state_q == SCAN) && win_ready && !abort;
   assign level_end  = wrap_row && wrap_frame;
   assign frame_end  = accept && level_end && !next_lvl.found;

   assign win_last  = (state_q == SCAN) && level_end && !next_lvl.found;
   assign win_level = level_q;

   always_comb begin
      state_d   = state_q;
      win_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = (|elig_in) ? SETTLE : DONE;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (enter_scan) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            busy      = 1'b1;
            win_valid = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (frame_end) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         elig_q     <= '0;
         level_q    <= '0;
         settle_cnt <= '0;
         win_count  <= '0;
         for (int l = 0; l < LEVELS; l++) begin
            width_q[l]  <= '0;
            height_q[l] <= '0;
         end
      end else begin
         state_q <= state_d;

         if (start_ok) begin
            for (int l = 0; l < LEVELS; l++) begin
               width_q[l]  <= level_width[l*COORD_W +: COORD_W];
               height_q[l] <= level_height[l*COORD_W +: COORD_W];
            end
            elig_q     <= elig_in;
            win_count  <= '0;
            settle_cnt <= SETTLE_LOAD;
         end

         if (state_q == SETTLE) begin
            settle_cnt <= settle_cnt - 16'd1;
         end

         if (enter_scan) begin
            level_q <= first_lvl.level;
         end

         if (accept) begin
            win_count <= win_count + 32'd1;
            if (level_end && next_lvl.found) begin
               level_q <= next_lvl.level;
            end
         end
      end
   end

   scan_coord_counter #(
      .COORD_W (COORD_W),
      .STRIDE  (STRIDE)
   ) u_coord (
      .clock      (clock),
      .reset      (reset),
      .clear      (enter_scan),
      .step       (accept),
      .max_row    (max_row),
      .max_col    (max_col),
      .row        (win_row),
      .col        (win_col),
      .wrap_row   (wrap_row),
      .wrap_frame (wrap_frame)
   );

endmodule

// File: tb/tb_scan_window_sequencer.sv
// Directed bench for scan_window_sequencer.
//   dut_a: LEVELS=3, WINDOW_SIZE=2, STRIDE=1, SETTLE_CYCLES=10
//   dut_b: LEVELS=1, WINDOW_SIZE=2, STRIDE=2, SETTLE_CYCLES=4
// Inputs are driven and outputs sampled on the falling edge.
module tb_scan_window_sequencer;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic        a_start, a_abort, a_ready;
   logic [47:0] a_w, a_h;
   logic        a_valid, a_last, a_busy, a_done;
   logic [3:0]  a_level;
   logic [15:0] a_row, a_col;
   logic [31:0] a_count;

   logic        b_start, b_abort, b_ready;
   logic [15:0] b_w, b_h;
   logic        b_valid, b_last, b_busy, b_done;
   logic [3:0]  b_level;
   logic [15:0] b_row, b_col;
   logic [31:0] b_count;

   logic [63:0] got_q[$];
   logic [63:0] exp_q[$];
   int          last_lat;
   int          last_cyc;

   scan_window_sequencer #(
      .LEVELS(3), .WINDOW_SIZE(2), .STRIDE(1), .COORD_W(16), .SETTLE_CYCLES(10)
   ) dut_a (
      .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
      .level_width(a_w), .level_height(a_h),
      .win_valid(a_valid), .win_ready(a_ready), .win_level(a_level),
      .win_row(a_row), .win_col(a_col), .win_last(a_last),
      .busy(a_busy), .done(a_done), .win_count(a_count)
   );

   scan_window_sequencer #(
      .LEVELS(1), .WINDOW_SIZE(2), .STRIDE(2), .COORD_W(16), .SETTLE_CYCLES(4)
   ) dut_b (
      .clock(clock), .reset(reset), .start(b_start), .abort(b_abort),
      .level_width(b_w), .level_height(b_h),
      .win_valid(b_valid), .win_ready(b_ready), .win_level(b_level),
      .win_row(b_row), .win_col(b_col), .win_last(b_last),
      .busy(b_busy), .done(b_done), .win_count(b_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] wv(input int l, input int r, input int c, input int last);
      return {27'd0, 4'(l), 16'(r), 16'(c), 1'(last)};
   endfunction

   function automatic logic [63:0] win_a();
      return {27'd0, a_level, a_row, a_col, a_last};
   endfunction

   function automatic logic [63:0] win_b();
      return {27'd0, b_level, b_row, b_col, b_last};
   endfunction

   task automatic dims_a(input int w0, input int h0, input int w1, input int h1,
                         input int w2, input int h2);
      a_w = {16'(w2), 16'(w1), 16'(w0)};
      a_h = {16'(h2), 16'(h1), 16'(h0)};
   endtask

   task automatic compare_windows(input string tag);
      check({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   // Start a frame on dut_a and collect accepted windows until done.
   // Optionally stalls win_ready at one window index and pokes start mid-scan.
   task automatic run_frame_a(input int stall_idx, input int stall_len, input bit poke);
      int          stalled = 0;
      logic [63:0] snap = '0;
      got_q.delete();
      a_ready = 1'b1;
      a_start = 1'b1;
      @(negedge clock);
      a_start  = 1'b0;
      last_lat = 1;
      while (!a_valid && !a_done && last_lat < 100) begin
         @(negedge clock);
         last_lat++;
      end
      last_cyc = 0;
      while (!a_done && last_cyc < 200) begin
         if (a_valid && got_q.size() == stall_idx && stalled < stall_len) begin
            if (stalled == 0) begin
               snap = win_a();
            end else begin
               check("bp_hold", win_a(), snap);
               check("bp_count", 64'(a_count), 64'(stall_idx));
            end
            a_ready = 1'b0;
            stalled++;
         end else begin
            a_ready = 1'b1;
            a_start = poke && (got_q.size() == 2);
            if (a_valid) got_q.push_back(win_a());
         end
         @(negedge clock);
         last_cyc++;
      end
      a_ready = 1'b1;
      a_start = 1'b0;
      check("frame_done", 64'(a_done), 64'd1);
   endtask

   task automatic check_idle_a(input string tag, input int count);
      check({tag, "_valid"}, 64'(a_valid), 64'd0);
      check({tag, "_busy"},  64'(a_busy),  64'd0);
      check({tag, "_done"},  64'(a_done),  64'd0);
      check({tag, "_count"}, 64'(a_count), 64'(count));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cyc;
      reset   = 1'b1;
      a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1; a_w = '0; a_h = '0;
      b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1; b_w = '0; b_h = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Reset state
      check_idle_a("rst", 0);
      check("rst_last", 64'(a_last), 64'd0);
      check("rst_pos",  win_a(), wv(0, 0, 0, 0));

      // Basic walk, single 4x4 level
      dims_a(4, 4, 0, 0, 0, 0);
      run_frame_a(-1, 0, 1'b0);
      check("walk_lat", 64'(last_lat), 64'd10);
      check("walk_cyc", 64'(last_cyc), 64'd4);
      exp_q = {wv(0, 0, 0, 0), wv(0, 0, 1, 0), wv(0, 1, 0, 0), wv(0, 1, 1, 1)};
      compare_windows("walk");
      check("walk_count", 64'(a_count), 64'd4);
      check("walk_busy_in_done", 64'(a_busy), 64'd0);
      // start in the DONE cycle must be ignored
      a_start = 1'b1;
      @(negedge clock);
      a_start = 1'b0;
      check_idle_a("done_start", 4);

      // Level skip: level1 too narrow, level2 is a single window
      dims_a(4, 4, 2, 5, 3, 3);
      run_frame_a(-1, 0, 1'b0);
      exp_q = {wv(0, 0, 0, 0), wv(0, 0, 1, 0), wv(0, 1, 0, 0), wv(0, 1, 1, 0), wv(2, 0, 0, 1)};
      compare_windows("skip");
      check("skip_count", 64'(a_count), 64'd5);
      @(negedge clock);

      // Backpressure at (0,1) for 5 cycles, plus start poked mid-scan
      dims_a(4, 4, 0, 0, 0, 0);
      run_frame_a(1, 5, 1'b1);
      check("bp_cyc", 64'(last_cyc), 64'd9);
      exp_q = {wv(0, 0, 0, 0), wv(0, 0, 1, 0), wv(0, 1, 0, 0), wv(0, 1, 1, 1)};
      compare_windows("bp");
      check("bp_final_count", 64'(a_count), 64'd4);
      @(negedge clock);

      // No eligible level: done one cycle after start, count cleared
      dims_a(2, 2, 0, 0, 1, 1);
      run_frame_a(-1, 0, 1'b0);
      check("small_lat", 64'(last_lat), 64'd1);
      check("small_n", 64'(got_q.size()), 64'd0);
      check("small_count", 64'(a_count), 64'd0);
      @(negedge clock);

      // Abort during the second window
      dims_a(4, 4, 0, 0, 0, 0);
      a_start = 1'b1;
      @(negedge clock);
      a_start = 1'b0;
      lat = 1;
      while (!a_valid && lat < 100) begin @(negedge clock); lat++; end
      check("abort_lat", 64'(lat), 64'd10);
      @(negedge clock);
      check("abort_win2", win_a(), wv(0, 0, 1, 0));
      a_abort = 1'b1;
      @(negedge clock);
      a_abort = 1'b0;
      check_idle_a("abort", 1);
      @(negedge clock);
      check("abort_no_done", 64'(a_done), 64'd0);

      // Reset mid-scan
      dims_a(4, 4, 2, 5, 3, 3);
      a_start = 1'b1;
      @(negedge clock);
      a_start = 1'b0;
      lat = 1;
      while (!a_valid && lat < 100) begin @(negedge clock); lat++; end
      repeat (2) @(negedge clock);
      check("mid_win3", win_a(), wv(0, 1, 0, 0));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_idle_a("midrst", 0);
      check("midrst_pos", win_a(), wv(0, 0, 0, 0));

      // Stride 2 on a 6x6 level (dut_b)
      b_w = 16'd6;
      b_h = 16'd6;
      got_q.delete();
      b_start = 1'b1;
      @(negedge clock);
      b_start = 1'b0;
      lat = 1;
      while (!b_valid && lat < 100) begin @(negedge clock); lat++; end
      check("stride_lat", 64'(lat), 64'd4);
      cyc = 0;
      while (!b_done && cyc < 50) begin
         if (b_valid) got_q.push_back(win_b());
         @(negedge clock);
         cyc++;
      end
      check("stride_done", 64'(b_done), 64'd1);
      exp_q = {wv(0, 0, 0, 0), wv(0, 0, 2, 0), wv(0, 2, 0, 0), wv(0, 2, 2, 1)};
      compare_windows("stride");
      check("stride_count", 64'(b_count), 64'd4);
      @(negedge clock);
      check("stride_idle_busy", 64'(b_busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
